// File: rtl/ljpeg_pkg.sv
// Shared LJPEG front-end definitions: default geometry, pixel-word types and the
// row-length clamp used by the row buffer.
package ljpeg_pkg;

  localparam int DEFAULT_PIXEL_BITS    = 12;
  localparam int DEFAULT_PIXELS        = 16;
  localparam int DEFAULT_MAX_ROW_WORDS = 32;

  typedef logic [DEFAULT_PIXEL_BITS-1:0]   pixel_t;
  typedef pixel_t [DEFAULT_PIXELS-1:0]     pixel_word_t;

  // Control flags that travel with a beat into the output register stage.
  typedef struct packed {
    logic vld;
    logic new_row;
    logic row0;
  } beat_ctl_t;

  // A programmed length of 0 or beyond the buffer depth means "full depth".
  function automatic int unsigned clamp_row_words(input int unsigned rw,
                                                  input int unsigned max_words);
    if (rw == 0 || rw > max_words) return max_words;
    return rw;
  endfunction

endpackage

// File: rtl/row_buffer_stage_if.sv
// Pixel stream bus of the row buffer: beat input side plus delayed beat and
// previous-row outputs. master = producer/consumer side, slave = the stage.
interface row_buffer_stage_if
  import ljpeg_pkg::*;
#(
  parameter int PIXEL_BITS    = DEFAULT_PIXEL_BITS,
  parameter int PIXELS        = DEFAULT_PIXELS,
  parameter int MAX_ROW_WORDS = DEFAULT_MAX_ROW_WORDS
);
  localparam int ADDR_BITS = $clog2(MAX_ROW_WORDS);
  localparam int WORD_BITS = PIXELS * PIXEL_BITS;

  logic [ADDR_BITS:0]   row_words;
  logic [WORD_BITS-1:0] pixels_input;
  logic                 input_valid;
  logic                 pause_signal;
  logic                 end_in;
  logic [WORD_BITS-1:0] pixels_output;
  logic [WORD_BITS-1:0] cached_pixels_output;
  logic                 output_valid;
  logic                 multi_row_mode;
  logic                 new_row;
  logic                 end_out;
  logic [15:0]          row_count;

  modport master (
    output row_words, pixels_input, input_valid, pause_signal, end_in,
    input  pixels_output, cached_pixels_output, output_valid, multi_row_mode,
           new_row, end_out, row_count
  );

  modport slave (
    input  row_words, pixels_input, input_valid, pause_signal, end_in,
    output pixels_output, cached_pixels_output, output_valid, multi_row_mode,
           new_row, end_out, row_count
  );

endinterface

// File: rtl/row_buffer_mem.sv
// Read-first single-port row memory with a registered read port; rd_en holds the
// read register so the previous-row word stays frozen while the stage is stalled.
module row_buffer_mem #(
  parameter int WIDTH     = 192,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both assignments sample the old contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[addr];
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/row_buffer_stage.sv
// Row buffer for the LJPEG encoder front end: forwards each beat after one cycle
// with the co-located beat of the previous row. Define ROW_BUFFER_ROW_COUNT_EN to
// build the saturating completed-row counter; otherwise row_count is tied to 0.
module row_buffer_stage
  import ljpeg_pkg::*;
#(
  parameter int PIXEL_BITS    = DEFAULT_PIXEL_BITS,
  parameter int PIXELS        = DEFAULT_PIXELS,
  parameter int MAX_ROW_WORDS = DEFAULT_MAX_ROW_WORDS,
  parameter int ADDR_BITS     = $clog2(MAX_ROW_WORDS)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  row_buffer_stage_if.slave  bus
);

  localparam int WORD_BITS = PIXELS * PIXEL_BITS;
  localparam logic [ADDR_BITS:0] MAX_LEN = (ADDR_BITS+1)'(MAX_ROW_WORDS);

  typedef logic [WORD_BITS-1:0] word_t;

  logic                 accept;
  logic                 at_col0;
  logic                 wrap;
  logic                 store;
  logic [ADDR_BITS-1:0] col;
  logic [ADDR_BITS:0]   row_len;
  logic [ADDR_BITS:0]   len_eff;
  logic                 row0;
  logic                 multi_row;
  logic                 end_flag;
  word_t                pix_p1;
  word_t                rd_data_p1;
  beat_ctl_t            ctl_p1;

  assign accept  = bus.input_valid & ~bus.pause_signal;
  assign at_col0 = (col == '0);
  // Row length is only re-sampled at column 0; mid-row changes wait for the next row.
  assign len_eff = at_col0
                 ? (ADDR_BITS+1)'(clamp_row_words(32'(bus.row_words), MAX_ROW_WORDS))
                 : row_len;
  assign wrap    = ({1'b0, col} == len_eff - (ADDR_BITS+1)'(1));
  assign store   = accept & ~bus.end_in & ~sys_rst;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      col       <= '0;
      row_len   <= MAX_LEN;
      row0      <= 1'b1;
      multi_row <= 1'b0;
      end_flag  <= 1'b0;
    end else if (!bus.pause_signal) begin
      if (bus.end_in) end_flag <= 1'b1;
      if (accept) begin
        if (at_col0) row_len <= len_eff;
        col <= wrap ? '0 : col + ADDR_BITS'(1);
        if (wrap) row0 <= 1'b0;
        if (!row0) multi_row <= 1'b1;
      end
    end
  end

  row_buffer_mem #(
    .WIDTH     (WORD_BITS),
    .DEPTH     (MAX_ROW_WORDS),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk     (sys_clk),
    .addr    (col),
    .rd_en   (accept),
    .wr_en   (store),
    .wr_data (bus.pixels_input),
    .rd_data (rd_data_p1)
  );

  // ---- stage p1: output register, aligned with the memory read register ----
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ctl_p1 <= '{vld: 1'b0, new_row: 1'b1, row0: 1'b1};
    end else if (!bus.pause_signal) begin
      ctl_p1.vld <= bus.input_valid;
      if (accept) begin
        ctl_p1.new_row <= at_col0;
        ctl_p1.row0    <= row0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)     pix_p1 <= '0;
    else if (accept) pix_p1 <= bus.pixels_input;
  end

`ifdef ROW_BUFFER_ROW_COUNT_EN
  logic [15:0] row_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst)            row_cnt <= '0;
    else if (accept && wrap) row_cnt <= sat_inc16(row_cnt);
  end

  assign bus.row_count = row_cnt;
`else
  assign bus.row_count = '0;
`endif

  // Row-0 beats have no meaningful history; the mask also covers uncleared memory.
  assign bus.pixels_output        = pix_p1;
  assign bus.cached_pixels_output = ctl_p1.row0 ? '0 : rd_data_p1;
  assign bus.output_valid         = ctl_p1.vld;
  assign bus.new_row              = ctl_p1.new_row;
  assign bus.multi_row_mode       = multi_row;
  assign bus.end_out              = end_flag;

endmodule

// File: tb/tb_row_buffer_stage.sv
// Directed bench for row_buffer_stage: row history, bubbles, pause, end marker,
// row-length change/clamp, row_len=1 and mid-row reset, with immediate assertions.
module tb_row_buffer_stage;

  localparam int PB = 12;
  localparam int NP = 16;
  localparam int MW = 32;
  localparam int WB = PB * NP;

`ifdef ROW_BUFFER_ROW_COUNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  row_buffer_stage_if #(.PIXEL_BITS(PB), .PIXELS(NP), .MAX_ROW_WORDS(MW)) bus ();

  row_buffer_stage #(.PIXEL_BITS(PB), .PIXELS(NP), .MAX_ROW_WORDS(MW)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int ck_tbl [12] = '{-1, -1, -1, -1, 0, 1, 2, 3, 4, 5, 8, 9};
  bit nr_tbl [12] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0};
  int rc_tbl [12] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3, 4};

  // Beat k: lane i carries k*16+i, so lane ordering errors are visible.
  function automatic logic [WB-1:0] w(input int k);
    logic [WB-1:0] r;
    r = '0;
    if (k >= 0)
      for (int i = 0; i < NP; i++) r[i*PB +: PB] = PB'(k * 16 + i);
    return r;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx,
                     input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int idx, input int pk, input int ck,
                            input logic vld, input logic nr, input logic mrm,
                            input logic eo, input int rc);
    chk({tag, ".pix"},       idx, bus.pixels_output,           w(pk));
    chk({tag, ".cached"},    idx, bus.cached_pixels_output,    w(ck));
    chk({tag, ".valid"},     idx, WB'(bus.output_valid),       WB'(vld));
    chk({tag, ".new_row"},   idx, WB'(bus.new_row),            WB'(nr));
    chk({tag, ".multi_row"}, idx, WB'(bus.multi_row_mode),     WB'(mrm));
    chk({tag, ".end_out"},   idx, WB'(bus.end_out),            WB'(eo));
    chk({tag, ".row_count"}, idx, WB'(bus.row_count),          RC_EN ? WB'(rc) : '0);
  endtask

  task automatic send(input int k, input logic em);
    bus.input_valid  = 1'b1;
    bus.pixels_input = w(k);
    bus.end_in       = em;
    bus.pause_signal = 1'b0;
    tick();
  endtask

  task automatic idle();
    bus.input_valid  = 1'b0;
    bus.end_in       = 1'b0;
    bus.pause_signal = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    sys_rst          = 1'b1;
    bus.input_valid  = 1'b0;
    bus.end_in       = 1'b0;
    bus.pause_signal = 1'b0;
    tick();
    sys_rst          = 1'b0;
  endtask

  initial begin
    sys_rst          = 1'b1;
    bus.row_words    = 6'd4;
    bus.pixels_input = '0;
    bus.input_valid  = 1'b0;
    bus.pause_signal = 1'b0;
    bus.end_in       = 1'b0;
    tick();
    tick();
    expect_out("reset", 0, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    sys_rst = 1'b0;

    // Basic row history, 4 beats per row
    for (int k = 0; k < 10; k++) begin
      send(k, 1'b0);
      expect_out("basic", k, k, (k < 4) ? -1 : k - 4, 1'b1, (k % 4) == 0, k >= 4, 1'b0,
                 (k + 1) / 4);
    end

    // Bubbles: valid 1,0,0,1
    send(10, 1'b0);
    expect_out("bubble", 10, 10, 6, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    idle();
    expect_out("bubble_gap", 1, 10, 6, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    idle();
    expect_out("bubble_gap", 2, 10, 6, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    send(11, 1'b0);
    expect_out("bubble", 11, 11, 7, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    send(12, 1'b0);
    expect_out("bubble", 12, 12, 8, 1'b1, 1'b1, 1'b1, 1'b0, 3);
    send(13, 1'b0);
    expect_out("row3", 13, 13, 9, 1'b1, 1'b0, 1'b1, 1'b0, 3);

    // Reset in the middle of row 3, with a beat presented
    bus.input_valid  = 1'b1;
    bus.pixels_input = w(50);
    sys_rst          = 1'b1;
    tick();
    expect_out("reset_mid", 0, -1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    sys_rst = 1'b0;
    for (int k = 100; k < 105; k++) begin
      send(k, 1'b0);
      expect_out("after_reset", k, k, (k < 104) ? -1 : 100, 1'b1, (k == 100) || (k == 104),
                 k == 104, 1'b0, (k - 99) / 4);
    end

    // Pause mid-row, 8 beats per row; end_in during pause must not register
    do_reset();
    bus.row_words = 6'd8;
    for (int k = 0; k < 12; k++) begin
      send(k, 1'b0);
      expect_out("pre_pause", k, k, (k < 8) ? -1 : k - 8, 1'b1, (k % 8) == 0, k >= 8, 1'b0,
                 (k + 1) / 8);
    end
    for (int c = 0; c < 5; c++) begin
      bus.pause_signal = 1'b1;
      bus.input_valid  = 1'b1;
      bus.pixels_input = w(12);
      bus.end_in       = (c < 2);
      tick();
      expect_out("pause", c, 11, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    end
    for (int k = 12; k < 17; k++) begin
      send(k, 1'b0);
      expect_out("post_pause", k, k, k - 8, 1'b1, k == 16, 1'b1, 1'b0, (k + 1) / 8);
    end

    // End marker on beat 6: forwarded, not stored
    do_reset();
    bus.row_words = 6'd4;
    for (int k = 0; k < 11; k++) begin
      send(k, k == 6);
      expect_out("end", k, k, (k < 4) ? -1 : ((k == 10) ? 2 : k - 4), 1'b1, (k % 4) == 0,
                 k >= 4, k >= 6, (k + 1) / 4);
    end

    // Row length 4 -> 2 mid-row 1, then 0 (clamped to 32)
    do_reset();
    bus.row_words = 6'd4;
    for (int k = 0; k < 12; k++) begin
      if (k == 5)  bus.row_words = 6'd2;
      if (k == 11) bus.row_words = 6'd0;
      send(k, 1'b0);
      expect_out("len_change", k, k, ck_tbl[k], 1'b1, nr_tbl[k], k >= 4, 1'b0, rc_tbl[k]);
    end
    for (int k = 12; k < 45; k++) begin
      send(k, 1'b0);
      chk("clamp.pix",     k, bus.pixels_output, w(k));
      chk("clamp.new_row", k, WB'(bus.new_row),  WB'((k == 12) || (k == 44)));
      if (k == 12) chk("clamp.cached", k, bus.cached_pixels_output, w(10));
      if (k == 13) chk("clamp.cached", k, bus.cached_pixels_output, w(11));
    end
    expect_out("clamp_wrap", 44, 44, 12, 1'b1, 1'b1, 1'b1, 1'b0, 5);

    // row_len = 1: every beat is column 0, history is the previous beat
    do_reset();
    bus.row_words = 6'd1;
    for (int k = 0; k < 4; k++) begin
      send(k, 1'b0);
      expect_out("len1", k, k, k - 1, 1'b1, 1'b1, k >= 1, 1'b0, k + 1);
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
